// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, parity modes, prescaler divisor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        longint num;
        longint den;
        den = longint'(baud) * longint'(oversample);
        num = longint'(clk_freq) + den / 2;
        return int'(num / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-clock tick every DIV clocks, realignable via restart.
// Latency: first tick DIV clocks after restart; tick is combinational from the count.
// Backpressure: none; free-running.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority vote, parity and stop-bit checks.
// Latency: result pulse one clock after the mid-bit vote of the final stop bit.
// Backpressure: none; the line cannot be stalled, so results are single-cycle pulses.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_raw,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic [2:0]           rx_state
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = 4;

    rx_state_t state, state_nxt;

    logic                 rx_meta, rx_s;
    logic                 restart, tick;
    logic [OSW-1:0]       os_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr;
    logic                 dv_nxt, pe_nxt, fe_nxt;

    logic at_a, at_b, at_mid, at_end;
    logic maj, last_data, last_stop, ferr_fin, par_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_raw;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign at_a   = tick && (os_cnt == OSW'(M - 1));
    assign at_b   = tick && (os_cnt == OSW'(M));
    assign at_mid = tick && (os_cnt == OSW'(M + 1));
    assign at_end = tick && (os_cnt == OSW'(OVERSAMPLE - 1));

    // Third vote is the live sample, so the bit resolves on the M+1 tick itself.
    assign maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign last_data = (bit_cnt == BCW'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BCW'(STOP_BITS - 1));
    assign ferr_fin  = ferr | ~maj;
    assign par_exp   = (^shreg) ^ (PARITY == PAR_ODD);

    assign rx_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        dv_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    restart   = 1'b1;
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (at_mid && maj) begin
                    state_nxt = RX_IDLE;
                end else if (at_end) begin
                    state_nxt = RX_DATA;
                end
            end
            RX_DATA: begin
                if (at_end && last_data) begin
                    state_nxt = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (at_end) begin
                    state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                // Leave mid-bit so a start bit directly after the stop bit is not missed.
                if (at_mid && last_stop) begin
                    if (ferr_fin) begin
                        fe_nxt    = 1'b1;
                        state_nxt = RX_WAIT_IDLE;
                    end else if (perr) begin
                        pe_nxt    = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        dv_nxt    = 1'b1;
                        state_nxt = RX_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt       <= '0;
            bit_cnt      <= '0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shreg        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            data_valid   <= dv_nxt;
            parity_error <= pe_nxt;
            frame_error  <= fe_nxt;
            if (dv_nxt) begin
                data_out <= shreg;
            end

            if (restart) begin
                os_cnt  <= '0;
                bit_cnt <= '0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end else begin
                if (tick) begin
                    os_cnt <= at_end ? '0 : os_cnt + 1'b1;
                end
                if (at_end) begin
                    bit_cnt <= (((state == RX_DATA) && !last_data) || (state == RX_STOP))
                               ? bit_cnt + 1'b1 : '0;
                end
            end

            if (at_a) samp_a <= rx_s;
            if (at_b) samp_b <= rx_s;

            if ((state == RX_DATA) && at_mid) begin
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            end
            if ((state == RX_PARITY) && at_mid) begin
                perr <= (maj != par_exp);
            end
            if ((state == RX_STOP) && at_mid) begin
                ferr <= ferr_fin;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for three receiver configurations (8N2, 8E2, 7O2) sharing one clock and reset.
// Expected results are queued when a frame is driven and matched against result pulses.
module tb_uart_rx_param;

    localparam int BIT = 8680;

    typedef struct {
        int         inst;
        logic [2:0] kind;
        logic [8:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx_line;
    logic [2:0] dv, pe, fe;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic [2:0] st0, st1, st2;

    exp_t       sbq[$];
    logic [8:0] last_good [3];
    int         checks = 0;
    int         errors = 0;

    always #10 clk = ~clk;

    uart_rx_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_raw(rx_line[0]), .data_valid(dv[0]), .data_out(dout0),
        .parity_error(pe[0]), .frame_error(fe[0]), .rx_state(st0)
    );

    uart_rx_param #(.PARITY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_raw(rx_line[1]), .data_valid(dv[1]), .data_out(dout1),
        .parity_error(pe[1]), .frame_error(fe[1]), .rx_state(st1)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rx_raw(rx_line[2]), .data_valid(dv[2]), .data_out(dout2),
        .parity_error(pe[2]), .frame_error(fe[2]), .rx_state(st2)
    );

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [8:0] dout_of(input int i);
        case (i)
            0:       return {1'b0, dout0};
            1:       return {1'b0, dout1};
            default: return {2'b0, dout2};
        endcase
    endfunction

    function automatic logic [2:0] st_of(input int i);
        case (i)
            0:       return st0;
            1:       return st1;
            default: return st2;
        endcase
    endfunction

    // Scoreboard consumer: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if ((dv[i] | pe[i] | fe[i]) === 1'b1) begin
                chk($sformatf("pending_%0d", i), 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk($sformatf("inst_%0d", i), i, e.inst);
                    chk($sformatf("kind_%0d", i), {fe[i], pe[i], dv[i]}, e.kind);
                    chk($sformatf("data_%0d", i), dout_of(i), e.data);
                end
            end
        end
    end

    task automatic send_frame(input int inst, input logic [8:0] d, input int spike_bit,
                              input bit bad_par, input bit stop_low);
        int         nb;
        int         pm;
        logic [8:0] dm;
        logic       pbit;
        exp_t       e;
        nb   = (inst == 2) ? 7 : 8;
        pm   = (inst == 0) ? 0 : ((inst == 1) ? 2 : 1);
        dm   = d & 9'((1 << nb) - 1);
        pbit = (^dm) ^ (pm == 1) ^ bad_par;
        e.inst = inst;
        if (stop_low) begin
            e.kind = 3'b100;
            e.data = last_good[inst];
        end else if (bad_par && pm != 0) begin
            e.kind = 3'b010;
            e.data = last_good[inst];
        end else begin
            e.kind = 3'b001;
            e.data = dm;
            last_good[inst] = dm;
        end
        sbq.push_back(e);

        rx_line[inst] = 1'b0;
        #BIT;
        for (int b = 0; b < nb; b++) begin
            rx_line[inst] = dm[b];
            if (b == spike_bit) begin
                #(BIT / 2);
                rx_line[inst] = ~dm[b];
                #20;
                rx_line[inst] = dm[b];
                #(BIT / 2 - 20);
            end else begin
                #BIT;
            end
        end
        if (pm != 0) begin
            rx_line[inst] = pbit;
            #BIT;
        end
        for (int s = 0; s < 2; s++) begin
            rx_line[inst] = ~stop_low;
            #BIT;
        end
    endtask

    // Starts 0x81 and pulls reset in the middle of data bit 4.
    task automatic abort_frame(input int inst);
        logic [7:0] d;
        d = 8'h81;
        rx_line[inst] = 1'b0;
        #BIT;
        for (int b = 0; b < 4; b++) begin
            rx_line[inst] = d[b];
            #BIT;
        end
        rx_line[inst] = d[4];
        #(BIT / 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #3;
        chk($sformatf("abort_dv_%0d", inst), dv[inst], 1'b0);
        chk($sformatf("abort_pe_%0d", inst), pe[inst], 1'b0);
        chk($sformatf("abort_fe_%0d", inst), fe[inst], 1'b0);
        chk($sformatf("abort_state_%0d", inst), st_of(inst), 3'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_dout_%0d", i), dout_of(i), 9'd0);
            last_good[i] = 9'd0;
        end
        rx_line[inst] = 1'b1;
        #BIT;
        rst_n = 1'b1;
        #(2 * BIT);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_line = 3'b111;
        for (int i = 0; i < 3; i++) last_good[i] = 9'd0;
        #103;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_dv_%0d", i), dv[i], 1'b0);
            chk($sformatf("rst_pe_%0d", i), pe[i], 1'b0);
            chk($sformatf("rst_fe_%0d", i), fe[i], 1'b0);
            chk($sformatf("rst_dout_%0d", i), dout_of(i), 9'd0);
            chk($sformatf("rst_state_%0d", i), st_of(i), 3'd0);
        end
        rst_n = 1'b1;
        #(2 * BIT);

        send_frame(0, 9'h10, -1, 1'b0, 1'b0);

        send_frame(1, 9'hA5, -1, 1'b0, 1'b0);
        send_frame(1, 9'hA5, -1, 1'b1, 1'b0);

        send_frame(0, 9'h3C, -1, 1'b0, 1'b1);
        #BIT;
        @(negedge clk);
        chk("break_state", st0, 3'd5);
        rx_line[0] = 1'b1;
        #(2 * BIT);
        @(negedge clk);
        chk("break_recover_state", st0, 3'd0);
        send_frame(0, 9'h3C, -1, 1'b0, 1'b0);

        rx_line[0] = 1'b0;
        #1000;
        @(negedge clk);
        chk("glitch_start_state", st0, 3'd1);
        #1000;
        rx_line[0] = 1'b1;
        #BIT;
        @(negedge clk);
        chk("glitch_idle_state", st0, 3'd0);
        send_frame(0, 9'h55, 3, 1'b0, 1'b0);

        send_frame(0, 9'h00, -1, 1'b0, 1'b0);
        send_frame(0, 9'hFF, -1, 1'b0, 1'b0);
        send_frame(0, 9'h7E, -1, 1'b0, 1'b0);

        abort_frame(0);
        send_frame(0, 9'h81, -1, 1'b0, 1'b0);

        abort_frame(2);
        send_frame(2, 9'h81, -1, 1'b0, 1'b0);

        #BIT;
        chk("sb_drained", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
